// File: rtl/display_scheduler_pkg.sv
// Shared types for the display scheduler: FSM states, display sources and
// the source-to-select decode used by the output register.
package display_pkg;

    typedef enum logic [2:0] {
        CLK,
        COOK,
        TIMER,
        PEEK,
        ALERT
    } stateT;

    typedef enum logic [1:0] {
        SRC_C,
        SRC_K,
        SRC_T
    } srcT;

    localparam int IDLE_SEC_DEF  = 10;
    localparam int PEEK_SEC_DEF  = 3;
    localparam int ALERT_SEC_DEF = 5;
    localparam int CNT_W_DEF     = 4;

    // Bit order of the select vector is {ShowT, ShowK, ShowC}.
    function automatic logic [2:0] srcToSel(srcT src);
        logic [2:0] sel;
        sel = 3'b001;
        case (src)
            SRC_K:   sel = 3'b010;
            SRC_T:   sel = 3'b100;
            default: sel = 3'b001;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Signal bundle between the microwave front panel logic and the display
// scheduler; the master drives keys and status, the slave drives selects.
interface display_scheduler_if;
    import display_pkg::*;

    // No valid/ready here: Tick1Hz, Key*, *Done are single-cycle pulses that
    // are consumed on the edge they are seen, *Active are levels, and every
    // output is a registered level that changes one cycle after its cause.
    logic  Tick1Hz;
    logic  KeyClock;
    logic  KeyCook;
    logic  KeyTimer;
    logic  CookActive;
    logic  TimerActive;
    logic  CookDone;
    logic  TimerDone;
    logic  ShowC;
    logic  ShowK;
    logic  ShowT;
    logic  Blink;
    logic  AlertActive;
    stateT DbgState;

    modport master (
        output Tick1Hz, KeyClock, KeyCook, KeyTimer,
        output CookActive, TimerActive, CookDone, TimerDone,
        input  ShowC, ShowK, ShowT, Blink, AlertActive, DbgState
    );

    modport slave (
        input  Tick1Hz, KeyClock, KeyCook, KeyTimer,
        input  CookActive, TimerActive, CookDone, TimerDone,
        output ShowC, ShowK, ShowT, Blink, AlertActive, DbgState
    );

endinterface

// File: rtl/display_scheduler_tick_timeout.sv
// Counts second ticks since the last clear and flags the tick that brings
// the count up to Limit.
module tick_timeout #(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Clear,
    input  logic             Tick,
    input  logic [CNT_W-1:0] Limit,
    output logic             Expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (Clear) begin
            count <= '0;
        end else if (Tick) begin
            count <= count + CNT_W'(1);
        end
    end

    // Independent of Clear so the caller can let a key pre-empt the timeout.
    assign Expired = Tick && ((count + CNT_W'(1)) == Limit);

endmodule

// File: rtl/display_scheduler.sv
// Chooses which source the four-digit display shows (clock, cook, timer),
// handling key navigation, idle return, peeks and done alerts.
module display_scheduler
    import display_pkg::*;
#(
    parameter int IDLE_SEC  = IDLE_SEC_DEF,
    parameter int PEEK_SEC  = PEEK_SEC_DEF,
    parameter int ALERT_SEC = ALERT_SEC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic                Clock,
    input logic                nReset,
    display_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] IDLE_L  = CNT_W'(IDLE_SEC);
    localparam logic [CNT_W-1:0] PEEK_L  = CNT_W'(PEEK_SEC);
    localparam logic [CNT_W-1:0] ALERT_L = CNT_W'(ALERT_SEC);

    stateT stateQ, nState;
    stateT retQ, nRet;
    srcT   srcQ, nSrc;
    srcT   pendSrc, nPendSrc;
    srcT   nDisp;
    logic  pendV, nPendV;
    logic  blinkQ, nBlink;
    logic  restart;
    logic  [2:0] selQ;
    logic  alertQ;
    logic  cookActD, timerActD;

    logic  keyC, keyK, keyT, keyAny;
    srcT   keySrc, doneSrc, retSrc, effPendSrc;
    logic  doneAny, effPendV, cookRise, timerRise;
    logic  clear, expired;
    logic  [CNT_W-1:0] limit;

    assign keyC   = bus.KeyClock;
    assign keyK   = bus.KeyCook && !bus.KeyClock;
    assign keyT   = bus.KeyTimer && !bus.KeyClock && !bus.KeyCook;
    assign keyAny = keyC || keyK || keyT;
    assign keySrc = keyC ? SRC_C : (keyK ? SRC_K : SRC_T);

    assign doneAny    = bus.CookDone || bus.TimerDone;
    assign doneSrc    = bus.CookDone ? SRC_K : SRC_T;
    assign effPendV   = pendV || doneAny;
    assign effPendSrc = pendV ? pendSrc : doneSrc;
    assign retSrc     = (retQ == TIMER) ? SRC_T : SRC_K;

    assign cookRise  = bus.CookActive && !cookActD;
    assign timerRise = bus.TimerActive && !timerActD;

    always_comb begin
        limit = IDLE_L;
        case (stateQ)
            PEEK:    limit = PEEK_L;
            ALERT:   limit = ALERT_L;
            default: limit = IDLE_L;
        endcase
    end

    tick_timeout #(.CNT_W(CNT_W)) uTimeout (
        .Clock   (Clock),
        .nReset  (nReset),
        .Clear   (clear),
        .Tick    (bus.Tick1Hz),
        .Limit   (limit),
        .Expired (expired)
    );

    always_comb begin
        nState   = stateQ;
        nRet     = retQ;
        nSrc     = srcQ;
        nPendV   = pendV;
        nPendSrc = pendSrc;
        nBlink   = blinkQ;
        restart  = 1'b0;
        if (stateQ != ALERT && doneAny) begin
            nState   = ALERT;
            nSrc     = doneSrc;
            nPendV   = bus.CookDone && bus.TimerDone;
            nPendSrc = SRC_T;
            nBlink   = 1'b1;
        end else begin
            case (stateQ)
                CLK: begin
                    if (keyK)           nState = COOK;
                    else if (keyT)      nState = TIMER;
                    else if (cookRise)  nState = COOK;
                    else if (timerRise) nState = TIMER;
                end
                COOK: begin
                    if (bus.CookActive) begin
                        if (keyC || keyT) begin
                            nState = PEEK;
                            nSrc   = keySrc;
                            nRet   = COOK;
                        end
                    end else if (keyC)  nState  = CLK;
                    else if (keyT)      nState  = TIMER;
                    else if (keyK)      restart = 1'b1;
                    else if (expired)   nState  = CLK;
                end
                TIMER: begin
                    if (bus.TimerActive) begin
                        if (keyC || keyK) begin
                            nState = PEEK;
                            nSrc   = keySrc;
                            nRet   = TIMER;
                        end
                    end else if (keyC)  nState  = CLK;
                    else if (keyK)      nState  = COOK;
                    else if (keyT)      restart = 1'b1;
                    else if (expired)   nState  = CLK;
                end
                PEEK: begin
                    if (keyAny) begin
                        if (keySrc == retSrc) begin
                            nState = retQ;
                        end else begin
                            nSrc    = keySrc;
                            restart = 1'b1;
                        end
                    end else if (expired) begin
                        nState = retQ;
                    end
                end
                ALERT: begin
                    // A done pulse on the exit cycle still counts as pending.
                    if (keyAny || expired) begin
                        nPendV = 1'b0;
                        if (effPendV) begin
                            nSrc    = effPendSrc;
                            restart = 1'b1;
                            nBlink  = 1'b1;
                        end else begin
                            nState = CLK;
                        end
                    end else begin
                        nPendV   = effPendV;
                        nPendSrc = effPendSrc;
                        if (bus.Tick1Hz) nBlink = !blinkQ;
                    end
                end
                default: nState = CLK;
            endcase
        end
        if (nState != ALERT) nBlink = 1'b0;

        case (nState)
            CLK:     nDisp = SRC_C;
            COOK:    nDisp = SRC_K;
            TIMER:   nDisp = SRC_T;
            default: nDisp = nSrc;
        endcase
    end

    // Counter is held at zero whenever no timeout can apply in this state.
    assign clear = (nState != stateQ) || restart || (stateQ == CLK)
                || (stateQ == COOK && bus.CookActive)
                || (stateQ == TIMER && bus.TimerActive);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stateQ    <= CLK;
            retQ      <= COOK;
            srcQ      <= SRC_C;
            pendV     <= 1'b0;
            pendSrc   <= SRC_C;
            blinkQ    <= 1'b0;
            selQ      <= 3'b001;
            alertQ    <= 1'b0;
            cookActD  <= 1'b0;
            timerActD <= 1'b0;
        end else begin
            stateQ    <= nState;
            retQ      <= nRet;
            srcQ      <= nSrc;
            pendV     <= nPendV;
            pendSrc   <= nPendSrc;
            blinkQ    <= nBlink;
            selQ      <= srcToSel(nDisp);
            alertQ    <= (nState == ALERT);
            cookActD  <= bus.CookActive;
            timerActD <= bus.TimerActive;
        end
    end

    assign bus.ShowC       = selQ[0];
    assign bus.ShowK       = selQ[1];
    assign bus.ShowT       = selQ[2];
    assign bus.Blink       = blinkQ;
    assign bus.AlertActive = alertQ;
    assign bus.DbgState    = stateQ;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios with literal expectations
// followed by random traffic, all checked against an in-bench model.
module tb_display_scheduler;

    localparam int IDLE_SEC  = 10;
    localparam int PEEK_SEC  = 3;
    localparam int ALERT_SEC = 5;

    localparam int M_CLOCK = 0;
    localparam int M_COOK  = 1;
    localparam int M_TIMER = 2;
    localparam int M_PEEK  = 3;
    localparam int M_ALERT = 4;

    localparam byte CH_C = "C";
    localparam byte CH_K = "K";
    localparam byte CH_T = "T";

    logic Clock;
    logic nReset;
    int   checks;
    int   errors;
    int   cycle;

    display_scheduler_if bus ();

    display_scheduler #(
        .IDLE_SEC  (IDLE_SEC),
        .PEEK_SEC  (PEEK_SEC),
        .ALERT_SEC (ALERT_SEC),
        .CNT_W     (4)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- behavioural model ----------------
    int  m_mode;
    int  m_home;
    int  m_ticks;
    byte m_show;
    byte m_pend[$];
    bit  m_blink;
    bit  m_prevCook;
    bit  m_prevTimer;

    function automatic byte mode_disp(int mode);
        case (mode)
            M_COOK:  return CH_K;
            M_TIMER: return CH_T;
            default: return CH_C;
        endcase
    endfunction

    function automatic void go(int mode);
        m_mode  = mode;
        m_ticks = 0;
        m_blink = 1'b0;
    endfunction

    function automatic void go_alert(byte src);
        m_mode  = M_ALERT;
        m_show  = src;
        m_ticks = 0;
        m_blink = 1'b1;
    endfunction

    function automatic void alert_exit();
        byte s;
        if (m_pend.size() != 0) begin
            s = m_pend.pop_front();
            go_alert(s);
        end else begin
            go(M_CLOCK);
        end
    endfunction

    function automatic void model_reset();
        m_mode = M_CLOCK;
        m_home = M_COOK;
        m_ticks = 0;
        m_show = CH_C;
        m_pend.delete();
        m_blink = 1'b0;
        m_prevCook = 1'b0;
        m_prevTimer = 1'b0;
    endfunction

    function automatic void model_step();
        byte key, own, doneSrc;
        bit  tick, act, cookRise, timerRise, done;
        key = bus.KeyClock ? CH_C : (bus.KeyCook ? CH_K : (bus.KeyTimer ? CH_T : 8'd0));
        tick = bus.Tick1Hz;
        cookRise = bus.CookActive && !m_prevCook;
        timerRise = bus.TimerActive && !m_prevTimer;
        m_prevCook = bus.CookActive;
        m_prevTimer = bus.TimerActive;
        done = bus.CookDone || bus.TimerDone;
        doneSrc = bus.CookDone ? CH_K : CH_T;

        if (m_mode != M_ALERT && done) begin
            go_alert(doneSrc);
            m_pend.delete();
            if (bus.CookDone && bus.TimerDone) m_pend.push_back(CH_T);
        end else if (m_mode == M_CLOCK) begin
            if (key == CH_K)      go(M_COOK);
            else if (key == CH_T) go(M_TIMER);
            else if (cookRise)    go(M_COOK);
            else if (timerRise)   go(M_TIMER);
        end else if (m_mode == M_COOK || m_mode == M_TIMER) begin
            own = mode_disp(m_mode);
            act = (m_mode == M_COOK) ? bus.CookActive : bus.TimerActive;
            if (act) begin
                m_ticks = 0;
                if (key != 0 && key != own) begin
                    m_home = m_mode;
                    go(M_PEEK);
                    m_show = key;
                end
            end else if (key == own) begin
                m_ticks = 0;
            end else if (key != 0) begin
                go(key == CH_C ? M_CLOCK : (key == CH_K ? M_COOK : M_TIMER));
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == IDLE_SEC) go(M_CLOCK);
            end
        end else if (m_mode == M_PEEK) begin
            if (key == mode_disp(m_home)) begin
                go(m_home);
            end else if (key != 0) begin
                m_show = key;
                m_ticks = 0;
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == PEEK_SEC) go(m_home);
            end
        end else begin
            if (done && m_pend.size() == 0) m_pend.push_back(doneSrc);
            if (key != 0) begin
                alert_exit();
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == ALERT_SEC) alert_exit();
                else m_blink = !m_blink;
            end
        end
    endfunction

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) model_reset();
        else model_step();
    end

    function automatic logic [2:0] exp_sel();
        byte c;
        c = (m_mode == M_PEEK || m_mode == M_ALERT) ? m_show : mode_disp(m_mode);
        if (c == CH_K) return 3'b010;
        if (c == CH_T) return 3'b100;
        return 3'b001;
    endfunction

    // ---------------- checking ----------------
    task automatic compare();
        logic [2:0] got;
        logic [2:0] exp;
        got = {bus.ShowT, bus.ShowK, bus.ShowC};
        exp = exp_sel();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL select cyc=%0d got=%b exp=%b", cycle, got, exp);
        end
        checks++;
        if (bus.Blink !== m_blink) begin
            errors++;
            $display("FAIL blink cyc=%0d got=%b exp=%b", cycle, bus.Blink, m_blink);
        end
        checks++;
        if (bus.AlertActive !== (m_mode == M_ALERT)) begin
            errors++;
            $display("FAIL alert cyc=%0d got=%b exp=%b", cycle, bus.AlertActive, m_mode == M_ALERT);
        end
    endtask

    task automatic lit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cycle, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc();
        @(negedge Clock);
        cycle++;
        compare();
        bus.Tick1Hz   = 1'b0;
        bus.KeyClock  = 1'b0;
        bus.KeyCook   = 1'b0;
        bus.KeyTimer  = 1'b0;
        bus.CookDone  = 1'b0;
        bus.TimerDone = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.Tick1Hz = 1'b1;
            cyc();
            cyc();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle = 0;
        nReset = 1'b0;
        bus.Tick1Hz = 1'b0;
        bus.KeyClock = 1'b0;
        bus.KeyCook = 1'b0;
        bus.KeyTimer = 1'b0;
        bus.CookActive = 1'b0;
        bus.TimerActive = 1'b0;
        bus.CookDone = 1'b0;
        bus.TimerDone = 1'b0;
        repeat (3) cyc();
        lit("rst_showc", bus.ShowC, 1'b1);
        lit("rst_alert", bus.AlertActive, 1'b0);
        nReset = 1'b1;

        // Idle clock view survives any number of ticks.
        ticks(15);
        lit("idle_showc", bus.ShowC, 1'b1);
        lit("idle_blink", bus.Blink, 1'b0);

        // Inactive timer view times out after exactly IDLE_SEC ticks.
        bus.KeyTimer = 1'b1;
        cyc();
        lit("timer_enter", bus.ShowT, 1'b1);
        ticks(9);
        lit("timer_hold9", bus.ShowT, 1'b1);
        ticks(1);
        lit("timer_idle10", bus.ShowC, 1'b1);

        // Cooking: peek at the clock, return, and no idle timeout.
        bus.CookActive = 1'b1;
        cyc();
        lit("cook_enter", bus.ShowK, 1'b1);
        bus.KeyClock = 1'b1;
        cyc();
        lit("peek_c", bus.ShowC, 1'b1);
        ticks(2);
        lit("peek_hold", bus.ShowC, 1'b1);
        ticks(1);
        lit("peek_ret", bus.ShowK, 1'b1);
        ticks(30);
        lit("cook_no_to", bus.ShowK, 1'b1);

        // Simultaneous keys: clock beats timer.
        bus.KeyClock = 1'b1;
        bus.KeyTimer = 1'b1;
        cyc();
        lit("prio_c", bus.ShowC, 1'b1);
        bus.KeyCook = 1'b1;
        cyc();
        lit("peek_key_ret", bus.ShowK, 1'b1);

        // Both done pulses: cook alert first, timer alert pending.
        bus.CookActive = 1'b0;
        bus.CookDone = 1'b1;
        bus.TimerDone = 1'b1;
        cyc();
        lit("alert_k", bus.ShowK, 1'b1);
        lit("alert_on", bus.AlertActive, 1'b1);
        lit("blink_start", bus.Blink, 1'b1);
        ticks(1);
        lit("blink_t1", bus.Blink, 1'b0);
        ticks(3);
        lit("blink_t4", bus.Blink, 1'b1);
        ticks(1);
        lit("alert_t", bus.ShowT, 1'b1);
        lit("blink_restart", bus.Blink, 1'b1);
        ticks(5);
        lit("alert_done_c", bus.ShowC, 1'b1);
        lit("alert_off", bus.AlertActive, 1'b0);

        // Acknowledge by key.
        bus.TimerDone = 1'b1;
        cyc();
        lit("alert_t2", bus.ShowT, 1'b1);
        bus.KeyCook = 1'b1;
        cyc();
        lit("ack_c", bus.ShowC, 1'b1);
        lit("ack_off", bus.AlertActive, 1'b0);

        // Asynchronous reset in the middle of a peek.
        bus.TimerActive = 1'b1;
        cyc();
        bus.KeyCook = 1'b1;
        cyc();
        lit("peek_k", bus.ShowK, 1'b1);
        #2;
        nReset = 1'b0;
        #1;
        lit("arst_showc", bus.ShowC, 1'b1);
        lit("arst_showk", bus.ShowK, 1'b0);
        lit("arst_blink", bus.Blink, 1'b0);
        cyc();
        cyc();
        nReset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.Tick1Hz   = ($urandom_range(0, 2) == 0);
            bus.KeyClock  = ($urandom_range(0, 11) == 0);
            bus.KeyCook   = ($urandom_range(0, 11) == 0);
            bus.KeyTimer  = ($urandom_range(0, 11) == 0);
            bus.CookDone  = ($urandom_range(0, 39) == 0);
            bus.TimerDone = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) bus.CookActive = !bus.CookActive;
            if ($urandom_range(0, 29) == 0) bus.TimerActive = !bus.TimerActive;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Controller for the microwave's four-digit display multiplexer. It decides each cycle which source is shown: wall clock (C), cook time (K) or kitchen timer (T).
- Drives the one-hot select lines ShowC/ShowK/ShowT into the display selector, plus a blink enable for the digit drivers.
- Sequences key-driven mode changes, idle timeouts, short "peek" views while cooking, and end-of-cook/timer alerts.

Parameters:
- IDLE_SEC, 10, ticks of no key activity in an inactive COOK/TIMER view before returning to CLK.
- PEEK_SEC, 3, ticks a peeked display is held before returning.
- ALERT_SEC, 5, ticks an alert is held before auto-acknowledge.
- CNT_W, 4, tick-counter width; must satisfy 2^CNT_W > max(IDLE_SEC, PEEK_SEC, ALERT_SEC).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Tick1Hz  in  1  one-cycle pulse, once per second.
- KeyClock  in  1  debounced one-cycle key pulse.
- KeyCook  in  1  debounced one-cycle key pulse.
- KeyTimer  in  1  debounced one-cycle key pulse.
- CookActive  in  1  level; cook countdown running.
- TimerActive  in  1  level; kitchen timer running.
- CookDone  in  1  one-cycle pulse; cook countdown reached zero.
- TimerDone  in  1  one-cycle pulse; kitchen timer reached zero.
- ShowC  out  1  select clock digits.
- ShowK  out  1  select cook digits.
- ShowT  out  1  select timer digits.
- Blink  out  1  digit blank/flash enable.
- AlertActive  out  1  high while in ALERT; drives the buzzer.

Behaviour:
- Reset values: ShowC=1, ShowK=0, ShowT=0, Blink=0, AlertActive=0. State=CLK, counter=0, pending alert cleared.
- Outputs are registered; one-hot is always guaranteed. Latency is 1 cycle from the triggering input to the output change.
- Key priority on simultaneous pulses: KeyClock > KeyCook > KeyTimer. Only the highest key is acted on.
- Counter rules:
  - Counts Tick1Hz pulses and clears on every state change.
  - Timeout fires on the tick that makes the count equal N, i.e. exactly N ticks after entry or restart.
  - A key and a tick in the same cycle: the key wins and the counter clears.
- State CLK (ShowC):
  - KeyCook or CookActive rising edge -> COOK.
  - KeyTimer or TimerActive rising edge -> TIMER.
  - KeyClock: no effect.
- State COOK (ShowK):
  - CookActive=1: no timeout. KeyClock/KeyTimer -> PEEK with target C/T and return=COOK.
  - CookActive=0: idle count runs; IDLE_SEC -> CLK. KeyClock -> CLK; KeyTimer -> TIMER; KeyCook restarts the count.
- State TIMER (ShowT): symmetric to COOK, using TimerActive and KeyCook.
- State PEEK (shows target):
  - After PEEK_SEC ticks -> return state.
  - Key selecting the return state's display -> return immediately.
  - Key selecting another display retargets and restarts the count.
  - If the return state's Active drops during PEEK, the return is still to that state, which then applies its idle rule.
- Entering ALERT:
  - From any state, a CookDone pulse -> ALERT with src=K; a TimerDone pulse -> ALERT with src=T.
  - Both pulses in the same cycle: src=K, and T is latched as pending.
  - A Done pulse arriving during ALERT, or a second Done for a different source, sets pending (one slot; duplicates merge).
- State ALERT (shows src):
  - AlertActive=1; Blink toggles on each Tick1Hz, starting at 1 on entry.
  - Exits on any key (acknowledge) or after ALERT_SEC ticks.
  - If pending is set on exit -> ALERT with the pending source, pending cleared, counter cleared. Otherwise -> CLK.
  - Blink=0 outside ALERT.
- Reset mid-operation: immediate return to the reset values, and pending is lost.

Decomposition:
- Shared package display_pkg:
  - State enum: CLK, COOK, TIMER, PEEK, ALERT.
  - Display-source encoding: SRC_C, SRC_K, SRC_T.
  - Helper mapping a source to the one-hot select.
- One sub-module: tick_timeout (Clock, nReset, Clear, Tick, Limit -> Expired). Shared by all timeout paths.

Test Plan:
- Release nReset, no keys, 15 ticks -> ShowC=1 throughout, Blink=0, AlertActive=0.
- KeyTimer with TimerActive=0, then 10 ticks -> ShowT from cycle+1; ShowC on the cycle after tick 10, not before.
- CookActive=1 -> ShowK; KeyClock -> ShowC for 3 ticks -> ShowK; 30 further ticks -> remains ShowK.
- KeyClock and KeyTimer in the same cycle while in COOK -> PEEK target C, ShowC=1.
- CookDone and TimerDone in the same cycle -> ALERT with ShowK and Blink toggling for 5 ticks, then ALERT with ShowT for 5 ticks, then ShowC, AlertActive=0.
- During ALERT, KeyCook -> acknowledge and exit next cycle. Assert nReset low mid-PEEK -> outputs are the reset values asynchronously.
